// File: rtl/switch_debouncer.sv
// switch_debouncer: per-bit tick-sampled debounce of 16 DIP + 5 switch bits with edge pulses
module switch_debouncer #(
    parameter int SAMPLE_DIV     = 5000,
    parameter int STABLE_SAMPLES = 8,
    parameter bit RESET_LEVEL    = 1'b1,
    parameter bit SW_ACTIVE_LOW  = 1'b1
) (
    input  logic        i_CLK,
    input  logic        i_RESET,
    input  logic [15:0] i_DIP16,
    input  logic [4:0]  i_Switch5,
    output logic [15:0] o_DIP16,
    output logic [4:0]  o_Switch5,
    output logic [4:0]  o_Press5,
    output logic [4:0]  o_Release5,
    output logic        o_DIPChanged,
    output logic        o_Tick
);
    localparam int DW = $clog2(SAMPLE_DIV);
    logic [DW-1:0] div;
    logic [3:0]    cnt [21];
    logic [20:0]   raw, deb, upd;
    logic          tick;
    assign tick = div == DW'(SAMPLE_DIV - 1);
    assign raw = {i_Switch5, i_DIP16};
    assign {o_Switch5, o_DIP16} = deb;
    always_comb begin
        upd = '0;
        for (int i = 0; i < 21; i++)
            upd[i] = tick && raw[i] != deb[i] && cnt[i] == 4'(STABLE_SAMPLES - 1);
    end
    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            div          <= '0;
            deb          <= {21{RESET_LEVEL}};
            o_Press5     <= '0;
            o_Release5   <= '0;
            o_DIPChanged <= 1'b0;
            o_Tick       <= 1'b0;
            for (int i = 0; i < 21; i++)
                cnt[i] <= '0;
        end else begin
            div          <= tick ? '0 : div + 1'b1;
            o_Tick       <= tick;
            deb          <= deb ^ upd;
            o_Press5     <= upd[20:16] & (SW_ACTIVE_LOW ? ~raw[20:16] : raw[20:16]);
            o_Release5   <= upd[20:16] & (SW_ACTIVE_LOW ? raw[20:16] : ~raw[20:16]);
            o_DIPChanged <= |upd[15:0];
            for (int i = 0; i < 21; i++)
                if (tick)
                    cnt[i] <= (raw[i] == deb[i] || upd[i]) ? 4'd0 : cnt[i] + 4'd1;
        end
    end
endmodule
